phase_parser: RTL and testbench

- Downstream consumer of the host command receiver's `latest_data` / `phase_parse_en` / `phase_calib_en` outputs.
- Keeps per-channel shadow phase and calibration tables.
- On a host commit, waits for the next carrier period boundary. It then sweeps all channels one per cycle and loads the active phase bus with (shadow + calib) mod 2^PHASE_W.
- The active phase bus feeds the transducer PWM generators.

---
 rtl/phase_parser.sv | 224 ++++++++++++++++++++++
 tb/tb_phase_parser.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_parser.sv
//-----------------------------------------------------------------------------
// phase_parser
//
// Sits downstream of the host command receiver. Host phase and calibration
// writes land in per-channel shadow and calib tables. A commit request
// (parse strobe with address 8'hFF) arms a transfer. At the next carrier
// period boundary the block sweeps every channel, one per cycle, and loads
// the active table with (shadow + calib) mod 2^PHASE_W. The active table
// drives the transducer PWM generators through phases_out.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   data_in        receiver latest_data: [7:0] address,
//                  [8+PHASE_W-1:8] value, remaining bits ignored
//   phase_parse_en one-cycle strobe: shadow write (addr < NUM_CHANNELS)
//                  or commit request (addr == 8'hFF)
//   phase_calib_en one-cycle strobe: calibration write
//   period_tick    one-cycle pulse at the start of each carrier period
//   phases_out     active phases, channel i at [i*PHASE_W +: PHASE_W]
//   busy           high while a commit is armed or a sweep is running
//   commit_done    one-cycle pulse after the last channel is loaded
//   addr_error     one-cycle pulse after a strobe with an invalid address
//
// Parameters
//   NUM_CHANNELS   number of transducer channels (1..255)
//   PHASE_W        phase resolution in bits (1..8)
//-----------------------------------------------------------------------------
module phase_parser #(
  parameter int NUM_CHANNELS = 64,
  parameter int PHASE_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     data_in,
  input  logic                            phase_parse_en,
  input  logic                            phase_calib_en,
  input  logic                            period_tick,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phases_out,
  output logic                            busy,
  output logic                            commit_done,
  output logic                            addr_error
);

  localparam int               IDX_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [7:0]       NUM_CH_B    = 8'(NUM_CHANNELS);
  localparam logic [7:0]       COMMIT_ADDR = 8'hFF;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,   // nothing pending
    S_ARMED,  // commit accepted, waiting for the next period boundary
    S_COPY,   // loading one channel per cycle
    S_DONE    // single-cycle completion, commit_done high
  } state_e;

  typedef logic [PHASE_W-1:0] phase_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic [IDX_W-1:0] idx_q,         idx_d;
  logic             pending_q,     pending_d;
  logic             busy_q,        busy_d;
  logic             commit_done_q, commit_done_d;
  logic             addr_error_q,  addr_error_d;

  phase_t shadow_q [NUM_CHANNELS];
  phase_t shadow_d [NUM_CHANNELS];
  phase_t calib_q  [NUM_CHANNELS];
  phase_t calib_d  [NUM_CHANNELS];
  phase_t active_q [NUM_CHANNELS];
  phase_t active_d [NUM_CHANNELS];

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [7:0]       addr;
  phase_t           val;
  logic [IDX_W-1:0] addr_idx;
  logic             addr_valid;
  logic             parse_write;
  logic             parse_bad;
  logic             commit_req;
  logic             calib_write;
  logic             calib_bad;
  logic             unused_data;

  assign addr       = data_in[7:0];
  assign val        = data_in[8 +: PHASE_W];
  assign addr_idx   = addr[IDX_W-1:0];
  assign addr_valid = (addr < NUM_CH_B);
  assign unused_data = ^data_in[31:8+PHASE_W];

  assign parse_write = phase_parse_en && addr_valid;
  assign commit_req  = phase_parse_en && (addr == COMMIT_ADDR);
  assign parse_bad   = phase_parse_en && !addr_valid && (addr != COMMIT_ADDR);

  // The parse strobe wins a collision; the calib strobe is then dropped
  // without raising addr_error, whatever its address.
  assign calib_write = phase_calib_en && !phase_parse_en && addr_valid;
  assign calib_bad   = phase_calib_en && !phase_parse_en && !addr_valid;

  // Single shared adder for the sweep. Reads use the registered tables, so a
  // write to the channel being copied in the same cycle only reaches the next
  // sweep, while writes ahead of the sweep index are picked up by this one.
  phase_t sweep_sum;
  assign sweep_sum = shadow_q[idx_q] + calib_q[idx_q];

  // ---------------------------------------------------------------------------
  // Table next-state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first (here,
  // hold the current value); a path that leaves one unassigned infers a latch.
  always_comb begin
    shadow_d = shadow_q;
    calib_d  = calib_q;
    active_d = active_q;
    if (parse_write) shadow_d[addr_idx] = val;
    if (calib_write) calib_d[addr_idx]  = val;
    if (state_q == S_COPY) active_d[idx_q] = sweep_sum;
  end

  // ---------------------------------------------------------------------------
  // Control FSM next-state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;

    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        // A tick coinciding with the request is deliberately not used.
        if (commit_req) state_d = S_ARMED;
      end

      S_ARMED: begin
        // Further commit requests merge into the armed one.
        if (period_tick) begin
          state_d = S_COPY;
          idx_d   = '0;
        end
      end

      S_COPY: begin
        if (commit_req) pending_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        // A request landing in the DONE cycle itself is treated like one
        // already pending, so it is never lost.
        if (pending_q || commit_req) begin
          state_d   = S_ARMED;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        idx_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    busy_d        = (state_d != S_IDLE);
    commit_done_d = (state_d == S_DONE);
    addr_error_d  = parse_bad || calib_bad;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      addr_error_q  <= 1'b0;
      // NOTE: the tables are reset on purpose: a reset mid-sweep must leave
      // no partially loaded phases on the PWM bus. They are flop arrays, so
      // this costs no RAM inference.
      shadow_q      <= '{default: '0};
      calib_q       <= '{default: '0};
      active_q      <= '{default: '0};
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      addr_error_q  <= addr_error_d;
      shadow_q      <= shadow_d;
      calib_q       <= calib_d;
      active_q      <= active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_phase_out
    assign phases_out[i*PHASE_W +: PHASE_W] = active_q[i];
  end

  assign busy        = busy_q;
  assign commit_done = commit_done_q;
  assign addr_error  = addr_error_q;

endmodule

// File: tb/tb_phase_parser.sv
//-----------------------------------------------------------------------------
// tb_phase_parser
//
// Directed scenarios followed by randomized write/commit rounds. Expected
// values come from a table-level model: shadow/calib arrays updated by the
// strobe rules, and an active array recomputed as (shadow + calib) mod 2^W
// whenever a sweep starts.
//-----------------------------------------------------------------------------
module tb_phase_parser;

  localparam int N      = 64;
  localparam int PW     = 8;
  localparam int TOTAL  = N * PW;
  localparam int BUDGET = N + 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      din;
  logic             pe;
  logic             ce;
  logic             tick;
  logic [TOTAL-1:0] phases_out;
  logic             busy;
  logic             commit_done;
  logic             addr_error;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  logic [PW-1:0] m_shadow [N];
  logic [PW-1:0] m_calib  [N];
  logic [PW-1:0] m_active [N];

  phase_parser #(
    .NUM_CHANNELS (N),
    .PHASE_W      (PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .phase_parse_en (pe),
    .phase_calib_en (ce),
    .period_tick    (tick),
    .phases_out     (phases_out),
    .busy           (busy),
    .commit_done    (commit_done),
    .addr_error     (addr_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_calib[i]  = '0;
      m_active[i] = '0;
    end
  endtask

  // Applies one strobe cycle to the model; returns whether addr_error is due.
  task automatic m_strobe(input logic p, input logic c, input logic [7:0] addr,
                          input logic [PW-1:0] val, output logic err);
    int a;
    a   = int'(addr);
    err = 1'b0;
    if (p) begin
      if (a < N) m_shadow[a] = val;
      else if (a != 255) err = 1'b1;
    end else if (c) begin
      if (a < N) m_calib[a] = val;
      else err = 1'b1;
    end
  endtask

  task automatic m_sweep();
    for (int i = 0; i < N; i++) m_active[i] = PW'(int'(m_shadow[i]) + int'(m_calib[i]));
  endtask

  function automatic logic [TOTAL-1:0] m_vec();
    logic [TOTAL-1:0] v;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = m_active[i];
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [TOTAL-1:0] obs,
                       input logic [TOTAL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given strobes; outputs are sampled 1 time unit
  // after the edge. Upper data bits carry random junk.
  task automatic step(input logic p, input logic c, input logic t,
                      input logic [7:0] addr, input logic [PW-1:0] val);
    pe   = p;
    ce   = c;
    tick = t;
    din  = $urandom;
    din[7:0]    = addr;
    din[8 +: PW] = val;
    @(posedge clk);
    #1;
    pe   = 1'b0;
    ce   = 1'b0;
    tick = 1'b0;
    if (commit_done === 1'b1) done_pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, '0);
  endtask

  task automatic commit();
    step(1'b1, 1'b0, 1'b0, 8'hFF, '0);
  endtask

  task automatic do_tick();
    step(1'b0, 1'b0, 1'b1, 8'h00, '0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (commit_done !== 1'b1 && n < BUDGET) begin
      idle(1);
      n++;
    end
    check(tag, commit_done, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic          err;
    logic [7:0]    addr;
    logic [PW-1:0] val;
    logic          p;
    logic          c;
    logic          armed;
    int            kind;

    rst  = 1'b1;
    pe   = 1'b0;
    ce   = 1'b0;
    tick = 1'b0;
    din  = '0;
    m_reset();
    idle(2);
    rst = 1'b0;
    check("reset_phases", phases_out, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_commit_done", commit_done, 1'b0);
    check("reset_addr_error", addr_error, 1'b0);

    // Single channel write, commit, sweep timing.
    m_strobe(1'b1, 1'b0, 8'h03, 8'h40, err);
    step(1'b1, 1'b0, 1'b0, 8'h03, 8'h40);
    check("t1_no_addr_error", addr_error, err);
    check("t1_write_not_live", phases_out, '0);
    commit();
    check("t1_busy_after_commit", busy, 1'b1);
    idle(2);
    check("t1_armed_busy", busy, 1'b1);
    check("t1_armed_no_sweep", phases_out, '0);
    done_pulses = 0;
    do_tick();
    m_sweep();
    idle(3);
    check("t1_ch3_before_copy4", phases_out[3*PW +: PW], 8'h00);
    idle(1);
    check("t1_ch3_after_copy4", phases_out[3*PW +: PW], 8'h40);
    idle(N - 5);
    check("t1_no_early_done", commit_done, 1'b0);
    check("t1_busy_in_copy", busy, 1'b1);
    idle(1);
    check("t1_done_at_n_plus_1", commit_done, 1'b1);
    check("t1_busy_in_done", busy, 1'b1);
    check("t1_phases", phases_out, m_vec());
    idle(1);
    check("t1_done_one_cycle", commit_done, 1'b0);
    check("t1_busy_dropped", busy, 1'b0);
    check("t1_single_pulse", done_pulses, 1);

    // Calibration wrap-around; calib alone does not reach the outputs.
    m_strobe(1'b0, 1'b1, 8'h05, 8'hF0, err);
    step(1'b0, 1'b1, 1'b0, 8'h05, 8'hF0);
    idle(2);
    check("t2_calib_not_live", phases_out, m_vec());
    m_strobe(1'b1, 1'b0, 8'h05, 8'h20, err);
    step(1'b1, 1'b0, 1'b0, 8'h05, 8'h20);
    commit();
    do_tick();
    m_sweep();
    wait_done("t2_done");
    check("t2_ch5_wrap", phases_out[5*PW +: PW], 8'h10);
    check("t2_phases", phases_out, m_vec());
    idle(1);

    // Address errors.
    step(1'b1, 1'b0, 1'b0, 8'(N), 8'h55);
    check("t3_parse_bad_pulse", addr_error, 1'b1);
    idle(1);
    check("t3_parse_bad_clear", addr_error, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'hFF, 8'h66);
    check("t3_calib_ff_pulse", addr_error, 1'b1);
    idle(1);
    check("t3_calib_ff_clear", addr_error, 1'b0);
    check("t3_phases_unchanged", phases_out, m_vec());
    check("t3_not_busy", busy, 1'b0);

    // Commit and shadow[0] write mid-sweep: second sweep picks it up.
    commit();
    done_pulses = 0;
    do_tick();
    m_sweep();
    idle(5);
    m_strobe(1'b1, 1'b0, 8'h00, 8'h77, err);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h77);
    commit();
    wait_done("t4_first_done");
    check("t4_first_keeps_old_ch0", phases_out, m_vec());
    check("t4_busy_in_done", busy, 1'b1);
    idle(1);
    check("t4_rearmed_busy", busy, 1'b1);
    idle(3);
    check("t4_waits_for_tick", phases_out[0 +: PW], 8'h00);
    do_tick();
    m_sweep();
    wait_done("t4_second_done");
    check("t4_second_loads_ch0", phases_out[0 +: PW], 8'h77);
    check("t4_phases", phases_out, m_vec());
    idle(1);
    check("t4_busy_dropped", busy, 1'b0);
    idle(N + 4);
    check("t4_two_pulses", done_pulses, 2);

    // Both strobes together: parse wins, calib dropped silently.
    m_strobe(1'b0, 1'b1, 8'h02, 8'h05, err);
    step(1'b0, 1'b1, 1'b0, 8'h02, 8'h05);
    m_strobe(1'b1, 1'b1, 8'h02, 8'h11, err);
    step(1'b1, 1'b1, 1'b0, 8'h02, 8'h11);
    check("t5_no_addr_error", addr_error, 1'b0);
    commit();
    do_tick();
    m_sweep();
    wait_done("t5_done");
    check("t5_ch2", phases_out[2*PW +: PW], 8'h16);
    check("t5_phases", phases_out, m_vec());
    idle(1);

    // Reset in the middle of a sweep.
    m_strobe(1'b1, 1'b0, 8'h0C, 8'h3C, err);
    step(1'b1, 1'b0, 1'b0, 8'h0C, 8'h3C);
    commit();
    do_tick();
    idle(10);
    check("t6_ch0_loaded_before_rst", phases_out[0 +: PW], 8'h77);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_reset();
    check("t6_rst_phases", phases_out, '0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_commit_done", commit_done, 1'b0);
    check("t6_rst_addr_error", addr_error, 1'b0);
    done_pulses = 0;
    do_tick();
    idle(N + 4);
    check("t6_no_sweep_after_rst", done_pulses, 0);
    check("t6_still_idle", busy, 1'b0);
    check("t6_phases_zero", phases_out, '0);
    // Tables were cleared too: a fresh commit loads all zeros.
    commit();
    do_tick();
    m_sweep();
    wait_done("t6_post_rst_done");
    check("t6_tables_cleared", phases_out, m_vec());
    idle(1);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      armed = 1'b0;
      for (int k = 0; k < 24; k++) begin
        kind = $urandom_range(0, 9);
        val  = PW'($urandom);
        p    = 1'b0;
        c    = 1'b0;
        addr = 8'($urandom_range(0, N - 1));
        case (kind)
          0, 1, 2, 3: p = 1'b1;
          4, 5, 6:    c = 1'b1;
          7: begin p = 1'b1; c = 1'b1; end
          8: begin p = 1'b1; addr = 8'($urandom_range(N, 255)); end
          default: begin c = 1'b1; addr = 8'($urandom_range(N, 255)); end
        endcase
        if (p && addr == 8'hFF) armed = 1'b1;
        m_strobe(p, c, addr, val, err);
        step(p, c, 1'b0, addr, val);
        check($sformatf("rnd%0d_%0d_addr_error", r, k), addr_error, err);
      end
      if (!armed) commit();
      check($sformatf("rnd%0d_busy", r), busy, 1'b1);
      check($sformatf("rnd%0d_no_early_load", r), phases_out, m_vec());
      do_tick();
      m_sweep();
      wait_done($sformatf("rnd%0d_done", r));
      check($sformatf("rnd%0d_phases", r), phases_out, m_vec());
      idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
